// File: rtl/neopixel_strip_ctrl.sv
// WS2812-class strip driver: per-pixel staging buffer, snapshot into a shadow
// shift register on go, and serialisation with parameterised bit/latch timing.
module neopixel_strip_ctrl #(
  parameter int NUM_PIXELS = 16,
  parameter int T0H        = 18,
  parameter int T0L        = 40,
  parameter int T1H        = 35,
  parameter int T1L        = 30,
  parameter int T_LATCH    = 2500,
  parameter int AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          wr_all,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          go,
  output logic          ready,
  output logic          done,
  output logic          neopixel_data
);

  // state   | meaning
  // BLANK   | clear both buffers, then send one all-zero frame
  // IDLE    | ready; go snapshots staging and starts a frame
  // HIGH    | line high for T1H/T0H of the current bit
  // LOW     | line low for T1L/T0L, then next bit or latch
  // LATCH   | line low for T_LATCH, done on the last cycle

  localparam int NBITS  = 24 * NUM_PIXELS;
  localparam int BW     = $clog2(NBITS);
  localparam int TMAX_H = (T0H > T1H) ? T0H : T1H;
  localparam int TMAX_L = (T0L > T1L) ? T0L : T1L;
  localparam int TMAX_B = (TMAX_H > TMAX_L) ? TMAX_H : TMAX_L;
  localparam int TMAX   = (TMAX_B > T_LATCH) ? TMAX_B : T_LATCH;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_BLANK = 3'd0,
    S_IDLE  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic [NBITS-1:0]  shadow, snap;
  logic [23:0]       staging [NUM_PIXELS];
  logic [23:0]       staging_nxt [NUM_PIXELS];
  logic              load, shift, clear_buf, addr_ok, cur_bit;

  assign addr_ok = ({1'b0, wr_addr} < (AW+1)'(NUM_PIXELS));
  assign cur_bit = shadow[NBITS-1];

  // Staging update is computed combinationally so a same-edge write lands in the snapshot.
  always_comb begin
    snap = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      staging_nxt[i] = staging[i];
      if (clear_buf)
        staging_nxt[i] = '0;
      else if (wr_all)
        staging_nxt[i] = wr_data;
      else if (wr_en && addr_ok && (wr_addr == AW'(i)))
        staging_nxt[i] = wr_data;
      snap[NBITS-1-24*i -: 24] = staging_nxt[i];
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    bit_nxt   = bit_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    clear_buf = 1'b0;
    case (state)
      S_BLANK: begin
        clear_buf = 1'b1;
        load      = 1'b1;
        bit_nxt   = '0;
        timer_nxt = TW'(T0H - 1);
        state_nxt = S_HIGH;
      end
      S_IDLE: begin
        if (go) begin
          load      = 1'b1;
          bit_nxt   = '0;
          timer_nxt = snap[NBITS-1] ? TW'(T1H - 1) : TW'(T0H - 1);
          state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (timer == '0) begin
          timer_nxt = cur_bit ? TW'(T1L - 1) : TW'(T0L - 1);
          state_nxt = S_LOW;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_LOW: begin
        if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else if (bit_cnt == BW'(NBITS - 1)) begin
          timer_nxt = TW'(T_LATCH - 1);
          state_nxt = S_LATCH;
        end else begin
          shift     = 1'b1;
          bit_nxt   = bit_cnt + 1'b1;
          timer_nxt = shadow[NBITS-2] ? TW'(T1H - 1) : TW'(T0H - 1);
          state_nxt = S_HIGH;
        end
      end
      S_LATCH: begin
        if (timer == '0)
          state_nxt = S_IDLE;
        else
          timer_nxt = timer - 1'b1;
      end
      default: state_nxt = S_BLANK;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_BLANK;
      timer         <= '0;
      bit_cnt       <= '0;
      shadow        <= '0;
      neopixel_data <= 1'b0;
      for (int i = 0; i < NUM_PIXELS; i++)
        staging[i] <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      bit_cnt       <= bit_nxt;
      neopixel_data <= (state_nxt == S_HIGH);
      for (int i = 0; i < NUM_PIXELS; i++)
        staging[i] <= staging_nxt[i];
      if (load)
        shadow <= snap;
      else if (shift)
        shadow <= {shadow[NBITS-2:0], 1'b0};
    end
  end

  assign ready = (state == S_IDLE);
  assign done  = (state == S_LATCH) && (timer == '0);

endmodule

// File: tb/tb_neopixel_strip_ctrl.sv
// Directed bench for neopixel_strip_ctrl: 3 pixels, default bit timing,
// short latch; decodes each frame from the serial line and checks it.
module tb_neopixel_strip_ctrl;
  localparam int NP  = 3;
  localparam int TL  = 50;
  localparam int T0H = 18, T0L = 40, T1H = 35, T1L = 30;
  localparam int NB  = 24 * NP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0, wr_all = 1'b0, go = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        ready, done, data;

  int errors = 0;
  int checks = 0;

  logic [NB-1:0] rx_bits;
  int            rx_terr, rx_len;
  bit            rx_to;

  neopixel_strip_ctrl #(.NUM_PIXELS(NP), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L),
                        .T_LATCH(TL)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_all(wr_all),
    .wr_addr(wr_addr), .wr_data(wr_data), .go(go), .ready(ready), .done(done),
    .neopixel_data(data)
  );

  always #5 clk = ~clk;

  // Decodes one frame; rx_len counts from first high cycle to the done cycle inclusive.
  task automatic rx_frame();
    int w, h, l;
    bit seen;
    rx_bits = '0; rx_terr = 0; rx_len = 0; rx_to = 0; w = 0; seen = 0;
    while (data !== 1'b1 && w < 20000) begin @(negedge clk); w++; end
    if (data !== 1'b1) begin rx_to = 1; return; end
    for (int b = 0; b < NB; b++) begin
      h = 0;
      while (data === 1'b1 && h < 200) begin h++; rx_len++; @(negedge clk); end
      l = 0;
      while (data === 1'b0 && !seen && l < 3000) begin
        l++; rx_len++;
        seen = (b == NB - 1) && (done === 1'b1);
        if (!seen) @(negedge clk);
      end
      if (h == T1H && l == T1L + ((b == NB - 1) ? TL : 0)) rx_bits[NB-1-b] = 1'b1;
      else if (h == T0H && l == T0L + ((b == NB - 1) ? TL : 0)) rx_bits[NB-1-b] = 1'b0;
      else rx_terr++;
    end
    if (!seen) rx_terr++;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [23:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_fill(input logic [23:0] d);
    wr_data = d; wr_all = 1'b1;
    @(negedge clk);
    wr_all = 1'b0;
  endtask

  task automatic start_go();
    int w = 0;
    while (ready !== 1'b1 && w < 20000) begin @(negedge clk); w++; end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (data !== 1'b0)  begin errors++; $display("FAIL reset_data: got %b want 0", data); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    reset_n = 1'b1;
    rx_frame();
    checks++; if (rx_to || rx_terr != 0) begin errors++; $display("FAIL blank_timing: timeout=%0d bad_slots=%0d want 0/0", rx_to, rx_terr); end
    checks++; if (rx_bits !== '0) begin errors++; $display("FAIL blank_bits: got %h want 0", rx_bits); end
    checks++; if (rx_len != 4226) begin errors++; $display("FAIL blank_len: got %0d want 4226", rx_len); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL blank_ready: got %b want 1", ready); end
  endtask

  task automatic test_single_write();
    do_write(2'd1, 24'h800001);
    start_go();
    checks++; if (data !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL go_accept: data=%b ready=%b want 1/0", data, ready); end
    rx_frame();
    checks++; if (rx_to || rx_terr != 0) begin errors++; $display("FAIL single_timing: timeout=%0d bad_slots=%0d want 0/0", rx_to, rx_terr); end
    checks++; if (rx_bits !== {24'h000000, 24'h800001, 24'h000000}) begin errors++; $display("FAIL single_bits: got %h want 000000800001000000", rx_bits); end
    checks++; if (rx_len != 4240) begin errors++; $display("FAIL single_len: got %0d want 4240", rx_len); end
  endtask

  task automatic test_fill();
    do_fill(24'hFFFFFF);
    start_go();
    rx_frame();
    checks++; if (rx_to || rx_terr != 0) begin errors++; $display("FAIL fill_timing: timeout=%0d bad_slots=%0d want 0/0", rx_to, rx_terr); end
    checks++; if (rx_bits !== {NB{1'b1}}) begin errors++; $display("FAIL fill_bits: got %h want all ones", rx_bits); end
    checks++; if (rx_len != 4730) begin errors++; $display("FAIL fill_len: got %0d want 4730", rx_len); end
  endtask

  task automatic test_isolation();
    do_fill(24'h000000);
    start_go();
    fork
      rx_frame();
      begin repeat (5 * 58 + 20) @(negedge clk); do_fill(24'hFFFFFF); end
    join
    checks++; if (rx_to || rx_terr != 0 || rx_bits !== '0) begin errors++; $display("FAIL isolate_cur: bits=%h bad_slots=%0d want 0/0", rx_bits, rx_terr); end
    start_go();
    rx_frame();
    checks++; if (rx_bits !== {NB{1'b1}} || rx_terr != 0) begin errors++; $display("FAIL isolate_next: bits=%h bad_slots=%0d want all ones/0", rx_bits, rx_terr); end
  endtask

  task automatic test_dropped_go_bounds();
    int highs = 0;
    do_fill(24'h111111);
    do_write(2'd3, 24'hABCDEF);
    start_go();
    fork
      rx_frame();
      begin repeat (1000) @(negedge clk); go = 1'b1; @(negedge clk); go = 1'b0; end
    join
    checks++; if (rx_bits !== {3{24'h111111}}) begin errors++; $display("FAIL bounds_bits: got %h want 111111111111111111", rx_bits); end
    checks++; if (rx_len != 4352 || rx_terr != 0) begin errors++; $display("FAIL bounds_len: got %0d bad_slots=%0d want 4352/0", rx_len, rx_terr); end
    repeat (300) begin @(negedge clk); if (data === 1'b1) highs++; end
    checks++; if (highs != 0 || ready !== 1'b1) begin errors++; $display("FAIL dropped_go: high_cycles=%0d ready=%b want 0/1", highs, ready); end
  endtask

  task automatic test_back_to_back();
    int w = 0;
    while (ready !== 1'b1 && w < 20000) begin @(negedge clk); w++; end
    go = 1'b1;
    @(negedge clk);
    rx_frame();
    checks++; if (rx_bits !== {3{24'h111111}} || rx_terr != 0) begin errors++; $display("FAIL b2b_first: bits=%h bad_slots=%0d", rx_bits, rx_terr); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || data !== 1'b0) begin errors++; $display("FAIL b2b_gap: ready=%b data=%b want 1/0", ready, data); end
    @(negedge clk);
    checks++; if (data !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL b2b_restart: data=%b ready=%b want 1/0", data, ready); end
    go = 1'b0;
    rx_frame();
    checks++; if (rx_len != 4352 || rx_terr != 0) begin errors++; $display("FAIL b2b_second: len=%0d bad_slots=%0d want 4352/0", rx_len, rx_terr); end
  endtask

  task automatic test_async_reset();
    do_fill(24'hFFFFFF);
    start_go();
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (data !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL async_reset: data=%b ready=%b want 0/0", data, ready); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rx_frame();
    checks++; if (rx_bits !== '0 || rx_len != 4226 || rx_terr != 0) begin errors++; $display("FAIL rst_blank: bits=%h len=%0d want 0/4226", rx_bits, rx_len); end
    start_go();
    rx_frame();
    checks++; if (rx_bits !== '0 || rx_terr != 0 || rx_to) begin errors++; $display("FAIL rst_staging: bits=%h bad_slots=%0d want 0/0", rx_bits, rx_terr); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_isolation();
    test_dropped_go_bounds();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/neopixel_strip_ctrl.md
# neopixel_strip_ctrl

Parametrised NeoPixel (WS2812-class) strip driver with a per-pixel frame buffer. It replaces the single-colour broadcast controller. Host logic writes individual pixel colours, or fills the strip with one colour, into a staging buffer at any time. A `go` handshake snapshots the staging buffer and serialises it to the strip, with bit and latch timing set by parameters.

## Interface
Parameters:
- `NUM_PIXELS`, 16: pixels in the strip; must be ≥1.
- `T0H`, 18: cycles high for a 0 bit; must be ≥1.
- `T0L`, 40: cycles low for a 0 bit; must be ≥1.
- `T1H`, 35: cycles high for a 1 bit; must be ≥1.
- `T1L`, 30: cycles low for a 1 bit; must be ≥1.
- `T_LATCH`, 2500: cycles low after the last bit (strip latch/reset); must be ≥1.
- `AW`, `$clog2(NUM_PIXELS)` (min 1): pixel address width; derived, do not override.

Ports:
- `CLOCK_50`, in, 1: single clock; all logic is rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `wr_en`, in, 1: write `wr_data` into staging[`wr_addr`].
- `wr_all`, in, 1: write `wr_data` into every staging entry; takes priority over `wr_en`.
- `wr_addr`, in, AW: pixel index; 0 is the pixel nearest the driver.
- `wr_data`, in, 24: colour in wire order {G[7:0], R[7:0], B[7:0]}.
- `go`, in, 1: request a frame transmission.
- `ready`, out, 1: idle; a `go` is accepted this cycle.
- `done`, out, 1: one-cycle pulse when a frame (including latch) completes.
- `neopixel_data`, out, 1: serial strip data, driven directly from a flop.

## Operation
- Storage:
  - Staging buffer: NUM_PIXELS × 24.
  - Shadow buffer: NUM_PIXELS × 24.
- Writes to staging are allowed in every state, including mid-frame, and never disturb the frame in flight.
- A write with `wr_addr` ≥ NUM_PIXELS is ignored.
- Acceptance: a `go` is accepted on an edge where `ready`=1 and `go`=1.
  - On that edge the shadow buffer is loaded with staging. A same-edge write is included in the snapshot (write-first).
- A `go` seen while `ready`=0 is dropped, not queued.
- Transmission order: pixel 0 first; within a pixel, bit 23 first. Total bits = 24·NUM_PIXELS.
- State machine:
  - BLANK (entered on reset): shadow and staging are cleared to zero, then the FSM goes to HIGH for a full all-zero frame, then LATCH, then IDLE. This blanks the strip.
  - IDLE: `ready`=1. On `go`, load shadow, set the bit counter to 0, go to HIGH.
  - HIGH: `neopixel_data`=1 for T1H or T0H cycles, per the current bit, then LOW.
  - LOW: `neopixel_data`=0 for T1L or T0L cycles. If the current bit is the last, go to LATCH; otherwise advance the bit and go to HIGH.
  - LATCH: `neopixel_data`=0 for T_LATCH cycles, then pulse `done` and go to IDLE.
- Counters:
  - Bit counter width is `$clog2(24·NUM_PIXELS)`.
  - Phase timer width covers the maximum of the timing parameters.
  - Neither counter wraps within a frame.
- Reset mid-frame:
  - `neopixel_data` drops to 0 immediately (asynchronously).
  - The frame is aborted and the BLANK sequence restarts.

## Timing
- During reset:
  - `neopixel_data`=0, `ready`=0, `done`=0.
  - Both buffers are zero.
  - FSM is in BLANK.
- After reset release, the first frame starts on the first edge; there is no `go` needed.
  - `ready` rises at cycle 1 + 24·NUM_PIXELS·(T0H+T0L) + T_LATCH, counted from the first edge after release.
- Accepted `go` at edge E:
  - `ready` is 0 from E+1.
  - `neopixel_data` rises at E+1.
- Each bit slot is exactly T_xH + T_xL cycles, with no gap between slots.
- After the last bit, the line is low for exactly T_LATCH cycles.
- `done` is high for the single cycle at frame end. `ready` is high from the following cycle onward.
  - Frame length from E+1 to the `done` cycle inclusive = Σ(bit slots) + T_LATCH.
- Back-to-back: `go` held high continuously gives a new frame every frame length + 1 cycle.
- `ready` and `done` are Moore outputs. `neopixel_data` is registered: no combinational path from any input to any output.

## Test plan
Default timing parameters unless noted.

1. **Reset blank.** NUM_PIXELS=2, T_LATCH=50, reset released, no `go`.
   - Expect 48 pulses, each 18 cycles high and 40 low, then 50 low.
   - Expect a `done` pulse, then `ready`=1.
2. **Single pixel write.** NUM_PIXELS=2.
   - Write addr 1 = 24'h800001, then `go`.
   - Bits 0–23 are all 0-pulses (18/40).
   - Bit 24 is a 1-pulse (35/30); bits 25–46 are 0; bit 47 is 1.
3. **Fill.** NUM_PIXELS=4.
   - `wr_all` with 24'hFFFFFF, then `go`.
   - Expect 96 consecutive 35/30 pulses.
   - Frame length = 96·65 + 2500 cycles.
4. **Write isolation mid-frame.**
   - Start a frame of all 24'h000000.
   - During bit 5, write every pixel to FFFFFF.
   - The current frame stays all-zero; the next `go` sends all ones.
5. **Dropped go and address bounds.** NUM_PIXELS=3.
   - Pulse `go` during the frame: no extra frame follows.
   - Write `wr_addr`=3 with data ABCDEF: no staging entry changes.
6. **Async reset mid-frame.**
   - Assert `reset_n`=0 during a HIGH phase: `neopixel_data`=0 within the same cycle.
   - After release, a full blank frame is sent.
   - A following `go` sends zeros, because staging was cleared.
